// File: rtl/relu_backprop.sv
// ---------------------------------------------------------------------------
// relu_backprop : captures ReLU masks on the forward pass, gates gradients back
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module relu_backprop #(
  parameter int N     = 8,
  parameter int DEPTH = 64,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fwd_valid,
  input  logic signed [2*N-1:0] fwd_product,
  input  logic                  fwd_last,
  output logic                  fwd_ready,
  input  logic                  bwd_valid,
  input  logic signed [2*N-1:0] bwd_grad,
  output logic                  bwd_ready,
  output logic                  out_valid,
  output logic signed [2*N-1:0] out_grad,
  input  logic                  out_ready,
  output logic [CW-1:0]         mask_count,
  output logic                  overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [0:0] {
    ST_CAPTURE  = 1'b0,
    ST_BACKWARD = 1'b1
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DEPTH-1:0]      r_mask;
  logic                  r_out_valid;
  logic signed [2*N-1:0] r_out_grad;
  logic                  r_overflow;

  logic w_full;
  logic w_fwd_acc;
  logic w_bwd_acc;
  logic w_positive;

  assign w_full     = (r_count == C_DEPTH);
  assign fwd_ready  = (r_state == ST_CAPTURE) && !w_full;
  assign bwd_ready  = (r_state == ST_BACKWARD) && (!r_out_valid || out_ready);
  assign w_fwd_acc  = fwd_valid && fwd_ready;
  assign w_bwd_acc  = bwd_valid && bwd_ready;
  // Strictly positive: sign bit clear and not all-zero.
  assign w_positive = !fwd_product[2*N-1] && (|fwd_product);

  assign out_valid  = r_out_valid;
  assign out_grad   = r_out_grad;
  assign mask_count = r_count;
  assign overflow   = r_overflow;

  // Mask storage needs no reset; entries are always written before being read.
  always_ff @(posedge clock) begin
    if (w_fwd_acc) begin
      r_mask[r_wr_ptr] <= w_positive;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_CAPTURE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_grad  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_CAPTURE: begin
          if (w_fwd_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count  <= r_count + 1'b1;
            if (fwd_last) begin
              r_state  <= ST_BACKWARD;
              r_rd_ptr <= '0;
            end
          end
          if (fwd_valid && w_full) begin
            r_overflow <= 1'b1;
          end
        end
        ST_BACKWARD: begin
          if (w_bwd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count - 1'b1;
            if (r_count == C_ONE) begin
              r_state  <= ST_CAPTURE;
              r_wr_ptr <= '0;
            end
          end
        end
        default: r_state <= ST_CAPTURE;
      endcase

      // Output register keeps draining regardless of the FSM state.
      if (w_bwd_acc) begin
        r_out_valid <= 1'b1;
        r_out_grad  <= r_mask[r_rd_ptr] ? bwd_grad : '0;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
